// File: rtl/alarm_clock_multi_if.sv
// Bundle of the alarm-clock core's button, pulse and display signals.
//  master : pulse source / button side (drives inputs, reads time, display, buzz)
//  slave  : the alarm_clock_multi core
interface alarm_clock_multi_if #(
  parameter int unsigned NALM = 4,
  parameter int unsigned AW   = (NALM > 1) ? $clog2(NALM) : 1
);
  logic            pulse;
  logic            timeset;
  logic            alarmset;
  logic            minadv;
  logic            hrsadv;
  logic [AW-1:0]   alm_sel;
  logic [NALM-1:0] alm_on;
  logic            snooze;
  logic            stop;
  logic [6:0]      tsec;
  logic [6:0]      tmin;
  logic [6:0]      thrs;
  logic [2:0]      tday;
  logic [6:0]      disp_min;
  logic [6:0]      disp_hrs;
  logic            buzz;
  logic [AW-1:0]   alm_idx;

  modport master (
    output pulse, timeset, alarmset, minadv, hrsadv, alm_sel, alm_on, snooze, stop,
    input  tsec, tmin, thrs, tday, disp_min, disp_hrs, buzz, alm_idx
  );

  modport slave (
    input  pulse, timeset, alarmset, minadv, hrsadv, alm_sel, alm_on, snooze, stop,
    output tsec, tmin, thrs, tday, disp_min, disp_hrs, buzz, alm_idx
  );
endinterface

// File: rtl/alarm_clock_multi.sv
// Alarm-clock core: sec/min/hrs/day counters, NALM alarm slots and a shared
// ring/snooze controller.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus.pulse  : 1/sec tick; all time and alarm-slot advance is qualified by it
//  bus.timeset/alarmset/minadv/hrsadv/alm_sel : manual set controls
//  bus.alm_on : per-slot enable; bus.snooze/stop : ring control buttons
//  bus.tsec/tmin/thrs/tday : time of day; bus.disp_min/disp_hrs : display mux
//  bus.buzz   : alarm sounding; bus.alm_idx : slot that caused the ring
module alarm_clock_multi #(
  parameter int unsigned NS         = 60,
  parameter int unsigned NM         = 60,
  parameter int unsigned NH         = 24,
  parameter int unsigned ND         = 7,
  parameter int unsigned NALM       = 4,
  parameter int unsigned SNOOZE_MIN = 9,
  parameter int unsigned RING_SEC   = 60
) (
  input logic              clk,
  input logic              rst_n,
  alarm_clock_multi_if.slave bus
);

  localparam int unsigned AW      = (NALM > 1) ? $clog2(NALM) : 1;
  localparam int unsigned SNZ_TOT = SNOOZE_MIN * NS;
  localparam int unsigned RW      = $clog2(RING_SEC + 1);
  localparam int unsigned ZW      = $clog2(SNZ_TOT + 1);

  localparam logic [6:0] SEC_MAX = 7'(NS - 1);
  localparam logic [6:0] MIN_MAX = 7'(NM - 1);
  localparam logic [6:0] HRS_MAX = 7'(NH - 1);
  localparam logic [2:0] DAY_MAX = 3'(ND - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

  logic [6:0]    tsec_q, tsec_d, tmin_q, tmin_d, thrs_q, thrs_d;
  logic [2:0]    tday_q, tday_d;
  logic [6:0]    amin_q [NALM];
  logic [6:0]    amin_d [NALM];
  logic [6:0]    ahrs_q [NALM];
  logic [6:0]    ahrs_d [NALM];
  state_e        state_q, state_d;
  logic [RW-1:0] ring_ct_q, ring_ct_d;
  logic [ZW-1:0] snz_ct_q, snz_ct_d;
  logic [AW-1:0] alm_idx_q, alm_idx_d;
  logic          buzz_q;
  logic          snooze_q;

  logic          set_t, set_a, sec_wrap, match, snz_rise, abort;
  logic [AW-1:0] match_idx;

  // Mode decode: both buttons high falls back to RUN
  assign set_t    = bus.timeset & ~bus.alarmset;
  assign set_a    = bus.alarmset & ~bus.timeset;
  assign snz_rise = bus.snooze & ~snooze_q;

  // Time-of-day counters
  always_comb begin : time_next
    tsec_d   = tsec_q;
    tmin_d   = tmin_q;
    thrs_d   = thrs_q;
    tday_d   = tday_q;
    sec_wrap = 1'b0;
    if (bus.pulse) begin
      if (set_t) begin
        // Manual advance never carries into the next field
        if (bus.minadv) tmin_d = (tmin_q == MIN_MAX) ? 7'd0 : tmin_q + 7'd1;
        if (bus.hrsadv) thrs_d = (thrs_q == HRS_MAX) ? 7'd0 : thrs_q + 7'd1;
      end else if (tsec_q == SEC_MAX) begin
        tsec_d   = 7'd0;
        sec_wrap = 1'b1;
        if (tmin_q == MIN_MAX) begin
          tmin_d = 7'd0;
          if (thrs_q == HRS_MAX) begin
            thrs_d = 7'd0;
            tday_d = (tday_q == DAY_MAX) ? 3'd0 : tday_q + 3'd1;
          end else begin
            thrs_d = thrs_q + 7'd1;
          end
        end else begin
          tmin_d = tmin_q + 7'd1;
        end
      end else begin
        tsec_d = tsec_q + 7'd1;
      end
    end
  end

  // Alarm slot editing and match against the post-update time
  always_comb begin : slot_next
    match     = 1'b0;
    match_idx = '0;
    for (int unsigned k = 0; k < NALM; k++) begin
      amin_d[k] = amin_q[k];
      ahrs_d[k] = ahrs_q[k];
      if (bus.pulse && set_a && (AW'(k) == bus.alm_sel)) begin
        if (bus.minadv) amin_d[k] = (amin_q[k] == MIN_MAX) ? 7'd0 : amin_q[k] + 7'd1;
        if (bus.hrsadv) ahrs_d[k] = (ahrs_q[k] == HRS_MAX) ? 7'd0 : ahrs_q[k] + 7'd1;
      end
      // Ascending scan with a sticky flag so the lowest index wins
      if (sec_wrap && !match && bus.alm_on[AW'(k)] &&
          (amin_q[k] == tmin_d) && (ahrs_q[k] == thrs_d)) begin
        match     = 1'b1;
        match_idx = AW'(k);
      end
    end
  end

  // Ring/snooze controller next state
  always_comb begin : fsm_next
    state_d   = state_q;
    ring_ct_d = ring_ct_q;
    snz_ct_d  = snz_ct_q;
    alm_idx_d = alm_idx_q;
    // Disabling the active slot or entering time-set cancels any ring/snooze
    abort     = set_t || ((state_q != ST_IDLE) && !bus.alm_on[alm_idx_q]);
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (match) begin
            state_d   = ST_RING;
            alm_idx_d = match_idx;
            ring_ct_d = RW'(RING_SEC);
          end
        end
        ST_RING: begin
          if (bus.stop) begin
            state_d = ST_IDLE;
          end else if (snz_rise) begin
            state_d  = ST_SNOOZE;
            snz_ct_d = ZW'(SNZ_TOT);
          end else if (bus.pulse) begin
            ring_ct_d = ring_ct_q - RW'(1);
            if (ring_ct_q == RW'(1)) state_d = ST_IDLE;
          end
        end
        ST_SNOOZE: begin
          if (bus.stop) begin
            state_d = ST_IDLE;
          end else if (bus.pulse) begin
            snz_ct_d = snz_ct_q - ZW'(1);
            if (snz_ct_q == ZW'(1)) begin
              state_d   = ST_RING;
              ring_ct_d = RW'(RING_SEC);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      tsec_q    <= '0;
      tmin_q    <= '0;
      thrs_q    <= '0;
      tday_q    <= '0;
      for (int unsigned k = 0; k < NALM; k++) begin
        amin_q[k] <= '0;
        ahrs_q[k] <= '0;
      end
      state_q   <= ST_IDLE;
      ring_ct_q <= '0;
      snz_ct_q  <= '0;
      alm_idx_q <= '0;
      buzz_q    <= 1'b0;
      snooze_q  <= 1'b0;
    end else begin
      tsec_q    <= tsec_d;
      tmin_q    <= tmin_d;
      thrs_q    <= thrs_d;
      tday_q    <= tday_d;
      for (int unsigned k = 0; k < NALM; k++) begin
        amin_q[k] <= amin_d[k];
        ahrs_q[k] <= ahrs_d[k];
      end
      state_q   <= state_d;
      ring_ct_q <= ring_ct_d;
      snz_ct_q  <= snz_ct_d;
      alm_idx_q <= alm_idx_d;
      // Tracks the state register exactly: high in every RING cycle
      buzz_q    <= (state_d == ST_RING);
      snooze_q  <= bus.snooze;
    end
  end

  assign bus.tsec     = tsec_q;
  assign bus.tmin     = tmin_q;
  assign bus.thrs     = thrs_q;
  assign bus.tday     = tday_q;
  assign bus.buzz     = buzz_q;
  assign bus.alm_idx  = alm_idx_q;
  // Display shows the selected slot while setting it, the time otherwise
  assign bus.disp_min = set_a ? amin_q[bus.alm_sel] : tmin_q;
  assign bus.disp_hrs = set_a ? ahrs_q[bus.alm_sel] : thrs_q;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Self-checking bench for alarm_clock_multi: directed table, hand-written
// alarm sequences and randomized stimulus against a seconds-of-week model.
module tb_alarm_clock_multi;
  localparam int unsigned NALM = 4;
  localparam int DAYSEC = 86400;
  localparam int WEEK   = 7 * DAYSEC;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alarm_clock_multi_if #(.NALM(NALM)) bus ();

  alarm_clock_multi #(
    .NS(60), .NM(60), .NH(24), .ND(7), .NALM(NALM), .SNOOZE_MIN(9), .RING_SEC(60)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: time as seconds since start of week
  int m_t;
  int m_amin [NALM];
  int m_ahrs [NALM];
  bit m_ring, m_snz, m_snz_prev;
  int m_ring_left, m_snz_left, m_idx;

  function automatic int m_sec(); return m_t % 60; endfunction
  function automatic int m_min(); return (m_t / 60) % 60; endfunction
  function automatic int m_hrs(); return (m_t / 3600) % 24; endfunction
  function automatic int m_day(); return m_t / DAYSEC; endfunction

  function automatic void model_reset();
    m_t = 0;
    for (int k = 0; k < int'(NALM); k++) begin m_amin[k] = 0; m_ahrs[k] = 0; end
    m_ring = 0; m_snz = 0; m_snz_prev = 0;
    m_ring_left = 0; m_snz_left = 0; m_idx = 0;
  endfunction

  // Applied at each active edge using the inputs present at that edge
  function automatic void model_step();
    bit st, sa, wrapped, hit, rise;
    int sec, mn, hr, dy, hidx, sel;
    st = bus.timeset && !bus.alarmset;
    sa = bus.alarmset && !bus.timeset;
    rise = bus.snooze && !m_snz_prev;
    sel = int'(bus.alm_sel);
    wrapped = 0; hit = 0; hidx = 0;
    sec = m_sec(); mn = m_min(); hr = m_hrs(); dy = m_day();
    if (bus.pulse) begin
      if (st) begin
        if (bus.minadv) mn = (mn + 1) % 60;
        if (bus.hrsadv) hr = (hr + 1) % 24;
        m_t = dy * DAYSEC + hr * 3600 + mn * 60 + sec;
      end else begin
        m_t = (m_t + 1) % WEEK;
        wrapped = (m_sec() == 0);
      end
    end
    if (wrapped)
      for (int k = int'(NALM) - 1; k >= 0; k--)
        if (bus.alm_on[k] && m_amin[k] == m_min() && m_ahrs[k] == m_hrs()) begin
          hit = 1; hidx = k;
        end
    if (bus.pulse && sa) begin
      if (bus.minadv) m_amin[sel] = (m_amin[sel] + 1) % 60;
      if (bus.hrsadv) m_ahrs[sel] = (m_ahrs[sel] + 1) % 24;
    end
    if (st || ((m_ring || m_snz) && !bus.alm_on[m_idx])) begin
      m_ring = 0; m_snz = 0;
    end else if (m_ring) begin
      if (bus.stop) m_ring = 0;
      else if (rise) begin m_ring = 0; m_snz = 1; m_snz_left = 540; end
      else if (bus.pulse) begin
        m_ring_left--;
        if (m_ring_left == 0) m_ring = 0;
      end
    end else if (m_snz) begin
      if (bus.stop) m_snz = 0;
      else if (bus.pulse) begin
        m_snz_left--;
        if (m_snz_left == 0) begin m_snz = 0; m_ring = 1; m_ring_left = 60; end
      end
    end else if (hit) begin
      m_ring = 1; m_idx = hidx; m_ring_left = 60;
    end
    m_snz_prev = bus.snooze;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int dmin, dhrs;
    if (bus.alarmset && !bus.timeset) begin
      dmin = m_amin[bus.alm_sel]; dhrs = m_ahrs[bus.alm_sel];
    end else begin
      dmin = m_min(); dhrs = m_hrs();
    end
    chk({tag, ".tsec"}, int'(bus.tsec), m_sec());
    chk({tag, ".tmin"}, int'(bus.tmin), m_min());
    chk({tag, ".thrs"}, int'(bus.thrs), m_hrs());
    chk({tag, ".tday"}, int'(bus.tday), m_day());
    chk({tag, ".disp_min"}, int'(bus.disp_min), dmin);
    chk({tag, ".disp_hrs"}, int'(bus.disp_hrs), dhrs);
    chk({tag, ".buzz"}, int'(bus.buzz), m_ring ? 1 : 0);
    chk({tag, ".alm_idx"}, int'(bus.alm_idx), m_idx);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".tsec"}, int'(bus.tsec), 0);
    chk({tag, ".tmin"}, int'(bus.tmin), 0);
    chk({tag, ".thrs"}, int'(bus.thrs), 0);
    chk({tag, ".tday"}, int'(bus.tday), 0);
    chk({tag, ".buzz"}, int'(bus.buzz), 0);
    chk({tag, ".alm_idx"}, int'(bus.alm_idx), 0);
  endtask

  task automatic idle_inputs();
    bus.pulse = 0; bus.timeset = 0; bus.alarmset = 0; bus.minadv = 0;
    bus.hrsadv = 0; bus.alm_sel = '0; bus.alm_on = '0; bus.snooze = 0; bus.stop = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic tick();
    bus.pulse = 1; step();
    bus.pulse = 0; step();
  endtask

  task automatic run_pulses(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset applied mid-cycle, released at the next falling edge
  task automatic do_reset(input bit check, input string tag);
    rst_n = 0;
    #2;
    if (check) chk_zero(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic set_hm(input int h, input int m);
    bus.timeset = 1;
    for (int i = 0; i < 100 && (m_hrs() != h || m_min() != m); i++) begin
      bus.minadv = (m_min() != m);
      bus.hrsadv = (m_hrs() != h);
      tick();
    end
    bus.timeset = 0; bus.minadv = 0; bus.hrsadv = 0;
  endtask

  // Brings the clock to 07:29:59 and crosses into 07:30 with slots 1,2 armed
  task automatic ring_up(input string tag);
    bus.alm_on = '0;
    set_hm(7, 29);
    run_pulses((59 - m_sec() + 60) % 60);
    bus.alm_on = 4'b0110;
    bus.pulse = 1; step();
    chk({tag, ".buzz_on"}, int'(bus.buzz), 1);
    chk({tag, ".alm_idx"}, int'(bus.alm_idx), 1);
    bus.pulse = 0; step();
  endtask

  typedef struct packed {
    logic       ts, as, ma, ha;
    logic [1:0] sel;
    logic       p;
    int         e_sec, e_min, e_hrs, e_dmin, e_dhrs;
  } vec_t;

  vec_t tbl [12];
  logic [31:0] r;

  initial begin
    // ts as ma ha sel p : sec min hrs dmin dhrs (from 00:00:00, slots 0)
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1, 0, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1, 1, 0, 1, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1, 2, 1, 2, 1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1, 2, 1, 2, 1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 2, 2, 1, 1, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 3, 2, 1, 1, 1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3, 2, 1, 0, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 4, 2, 1, 2, 1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4, 2, 1, 2, 1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4, 2, 2, 2, 2};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 5, 2, 2, 1, 1};

    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;

    // Directed mode/advance table
    foreach (tbl[i]) begin
      bus.timeset = tbl[i].ts; bus.alarmset = tbl[i].as;
      bus.minadv = tbl[i].ma; bus.hrsadv = tbl[i].ha;
      bus.alm_sel = tbl[i].sel; bus.pulse = tbl[i].p;
      step();
      chk($sformatf("tbl%0d.tsec", i), int'(bus.tsec), tbl[i].e_sec);
      chk($sformatf("tbl%0d.tmin", i), int'(bus.tmin), tbl[i].e_min);
      chk($sformatf("tbl%0d.thrs", i), int'(bus.thrs), tbl[i].e_hrs);
      chk($sformatf("tbl%0d.disp_min", i), int'(bus.disp_min), tbl[i].e_dmin);
      chk($sformatf("tbl%0d.disp_hrs", i), int'(bus.disp_hrs), tbl[i].e_dhrs);
      bus.pulse = 0;
    end
    idle_inputs();
    step();

    // One hour from reset
    do_reset(0, "rst1");
    run_pulses(3600);
    chk("hour.tsec", int'(bus.tsec), 0);
    chk("hour.tmin", int'(bus.tmin), 0);
    chk("hour.thrs", int'(bus.thrs), 1);
    chk("hour.tday", int'(bus.tday), 0);

    // Walk to the last second of the week, then wrap
    repeat (6) begin
      set_hm(23, 59);
      run_pulses(60);
    end
    set_hm(23, 59);
    run_pulses(59);
    chk("eow.tsec", int'(bus.tsec), 59);
    chk("eow.tmin", int'(bus.tmin), 59);
    chk("eow.thrs", int'(bus.thrs), 23);
    chk("eow.tday", int'(bus.tday), 6);
    tick();
    chk("wrap.tsec", int'(bus.tsec), 0);
    chk("wrap.tmin", int'(bus.tmin), 0);
    chk("wrap.thrs", int'(bus.thrs), 0);
    chk("wrap.tday", int'(bus.tday), 0);

    // Manual minute advance at :59 does not carry into hours
    set_hm(5, 59);
    run_pulses(7);
    bus.timeset = 1; bus.minadv = 1;
    tick();
    bus.timeset = 0; bus.minadv = 0;
    chk("setmin.tsec", int'(bus.tsec), 7);
    chk("setmin.tmin", int'(bus.tmin), 0);
    chk("setmin.thrs", int'(bus.thrs), 5);
    chk("setmin.tday", int'(bus.tday), 0);

    // Slots 1 and 2 set to 07:30; ring times out after 60 pulses
    do_reset(0, "rst2");
    bus.alarmset = 1;
    for (int s = 1; s <= 2; s++) begin
      bus.alm_sel = 2'(s);
      for (int i = 0; i < 30; i++) begin
        bus.minadv = 1; bus.hrsadv = (i < 7);
        tick();
      end
    end
    bus.alarmset = 0; bus.minadv = 0; bus.hrsadv = 0; bus.alm_sel = '0;
    ring_up("ring1");
    run_pulses(59);
    chk("ring1.still", int'(bus.buzz), 1);
    tick();
    chk("ring1.timeout", int'(bus.buzz), 0);

    // Snooze, re-ring after 540 pulses, then stop+snooze together
    ring_up("ring2");
    bus.snooze = 1; step();
    chk("snz.quiet", int'(bus.buzz), 0);
    run_pulses(539);
    chk("snz.539", int'(bus.buzz), 0);
    tick();
    chk("snz.540", int'(bus.buzz), 1);
    bus.snooze = 0; step();
    bus.snooze = 1; bus.stop = 1; step();
    chk("stop_snz.buzz", int'(bus.buzz), 0);
    bus.snooze = 0; bus.stop = 0;
    run_pulses(541);
    chk("stop_snz.idle", int'(bus.buzz), 0);
    check_model("post_stop");

    // Disabling the ringing slot silences it
    ring_up("ring3");
    bus.alm_on = 4'b0100; step();
    chk("alm_off.buzz", int'(bus.buzz), 0);

    // Entering time-set silences it
    ring_up("ring4");
    bus.timeset = 1; step();
    chk("timeset.buzz", int'(bus.buzz), 0);
    bus.timeset = 0;

    // Asynchronous reset while ringing
    ring_up("ring5");
    do_reset(1, "async_rst");

    // Randomized run against the model; slots k start at 00:0(k+1)
    idle_inputs();
    bus.alarmset = 1;
    for (int k = 0; k < int'(NALM); k++) begin
      bus.alm_sel = 2'(k);
      bus.minadv = 1;
      for (int j = 0; j <= k; j++) tick();
    end
    idle_inputs();
    bus.alm_on = 4'b1111;
    for (int c = 0; c < 6000 && n_err < 20; c++) begin
      r = $urandom;
      bus.pulse    = r[0];
      bus.timeset  = (r[6:1] == 6'd0);
      bus.alarmset = (r[11:7] == 5'd0);
      bus.minadv   = r[12];
      bus.hrsadv   = r[13] & r[14];
      bus.alm_sel  = r[16:15];
      if (r[22:17] == 6'd0) bus.alm_on = 4'($urandom);
      if (r[25:23] == 3'd0) bus.snooze = ~bus.snooze;
      bus.stop     = (r[31:26] == 6'd0);
      step();
      check_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
